// File: rtl/dwt_pkg.sv
// Shared types and constants for the line-buffered 1-D forward DWT.
// Covers the FSM state type, mode encodings, default 9/7 coefficients and the pass descriptor.
package dwt_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      COMPUTE = 2'd2,
      DRAIN   = 2'd3
   } state_t;

   localparam logic MODE_97 = 1'b0;
   localparam logic MODE_53 = 1'b1;

   // Coefficient register width; products are formed at IW+CW bits.
   localparam int CW = 18;

   localparam int C_ALPHA_DEF = -6497;
   localparam int C_BETA_DEF  = -217;
   localparam int C_GAMMA_DEF = 3616;
   localparam int C_DELTA_DEF = 1817;
   localparam int C_ZETA_DEF  = 4709;
   localparam int C_IZETA_DEF = 3563;

   typedef struct packed {
      logic                 odd;
      logic signed [CW-1:0] coef;
      logic                 is_scale;
   } pass_t;

endpackage

// File: rtl/lift_step.sv
// Single lifting/scaling datapath: 9/7 rounded update, 5/3 integer update, or band scaling.
// Results saturate to the internal width so a runaway value never wraps.
module lift_step
   import dwt_pkg::*;
#(
   parameter int IW   = 20,
   parameter int FRAC = 12
) (
   input  logic                 mode53,
   input  pass_t                desc,
   input  logic signed [CW-1:0] coef_b,
   input  logic signed [IW-1:0] x_a,
   input  logic signed [IW-1:0] x_b,
   input  logic signed [IW-1:0] l,
   input  logic signed [IW-1:0] r,
   output logic signed [IW-1:0] y_a,
   output logic signed [IW-1:0] y_b
);

   localparam int PW = IW + CW;
   localparam logic signed [PW-1:0] HALF = PW'(1) <<< (FRAC - 1);

   logic signed [CW-1:0] coef_a;
   logic signed [PW-1:0] opnd;
   logic signed [PW-1:0] prod_a;
   logic signed [PW-1:0] prod_b;
   logic signed [PW-1:0] wide;

   function automatic logic signed [IW-1:0] sat_iw(input logic signed [PW-1:0] v);
      if (v[PW-1:IW-1] == '0 || v[PW-1:IW-1] == '1) return v[IW-1:0];
      return v[PW-1] ? {1'b1, {(IW-1){1'b0}}} : {1'b0, {(IW-1){1'b1}}};
   endfunction

   always_comb begin
      coef_a = desc.coef;
      opnd   = desc.is_scale ? PW'(x_a) : PW'(l) + PW'(r);
      prod_a = opnd * PW'(coef_a);
      prod_b = PW'(x_b) * PW'(coef_b);
      if (desc.is_scale)
         wide = (prod_a + HALF) >>> FRAC;
      else if (!mode53)
         wide = PW'(x_a) + ((prod_a + HALF) >>> FRAC);
      else if (desc.odd)
         wide = PW'(x_a) - (opnd >>> 1);
      else
         wide = PW'(x_a) + ((opnd + PW'(2)) >>> 2);
      y_a = sat_iw(wide);
      y_b = desc.is_scale ? sat_iw((prod_b + HALF) >>> FRAC) : x_b;
   end

endmodule

// File: rtl/dwt_line_lift.sv
// One-level 1-D forward DWT (9/7 or 5/3) computed in place over a buffered line.
// Loads a line, runs one lifting position per cycle with symmetric extension, then streams (L,H) pairs.
module dwt_line_lift
   import dwt_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int GUARD   = 4,
   parameter int MAX_LEN = 64,
   parameter int FRAC    = 12,
   parameter int C_ALPHA = C_ALPHA_DEF,
   parameter int C_BETA  = C_BETA_DEF,
   parameter int C_GAMMA = C_GAMMA_DEF,
   parameter int C_DELTA = C_DELTA_DEF,
   parameter int C_ZETA  = C_ZETA_DEF,
   parameter int C_IZETA = C_IZETA_DEF
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    mode,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [WIDTH-1:0] in_data,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [WIDTH-1:0] out_low,
   output logic signed [WIDTH-1:0] out_high,
   output logic                    out_last,
   output logic                    busy,
   output logic                    err
);

   localparam int IW = WIDTH + GUARD;
   localparam int AW = $clog2(MAX_LEN);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] ONE        = LW'(1);
   localparam logic [LW-1:0] TWO        = LW'(2);
   localparam logic [LW-1:0] LEN_MAX_M1 = LW'(MAX_LEN - 1);

   state_t               state_q, state_d;
   logic                 mode_q, mode_d;
   logic [LW-1:0]        cnt_q, cnt_d, len_q, len_d, pos_q, pos_d;
   logic [2:0]           pass_q, pass_d;
   logic signed [IW-1:0] x_q [MAX_LEN];
   logic signed [IW-1:0] x_d [MAX_LEN];
   logic                 out_valid_q, out_valid_d, out_last_q, out_last_d, err_q, err_d;
   logic signed [WIDTH-1:0] out_low_q, out_low_d, out_high_q, out_high_d;

   pass_t                desc;
   logic                 last_pass;
   logic [LW-1:0]        half, two_pos;
   logic [AW-1:0]        idx_t, idx_l, idx_r, nxt_lo, nxt_hi;
   logic signed [IW-1:0] y_a, y_b;
   logic                 accept;

   function automatic logic signed [WIDTH-1:0] sat_out(input logic signed [IW-1:0] v);
      if (v[IW-1:WIDTH-1] == '0 || v[IW-1:WIDTH-1] == '1) return v[WIDTH-1:0];
      return v[IW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
   endfunction

   assign in_ready  = (state_q == IDLE) || (state_q == LOAD);
   assign busy      = (state_q != IDLE);
   assign accept    = in_valid && in_ready;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_low   = out_low_q;
   assign out_high  = out_high_q;
   assign err       = err_q;

   always_comb begin
      desc      = '0;
      last_pass = 1'b0;
      if (mode_q == MODE_97) begin
         case (pass_q)
            3'd0:    begin desc.odd = 1'b1; desc.coef = CW'(C_ALPHA); end
            3'd1:    desc.coef = CW'(C_BETA);
            3'd2:    begin desc.odd = 1'b1; desc.coef = CW'(C_GAMMA); end
            3'd3:    desc.coef = CW'(C_DELTA);
            default: begin desc.coef = CW'(C_ZETA); desc.is_scale = 1'b1; last_pass = 1'b1; end
         endcase
      end else begin
         desc.odd  = (pass_q == 3'd0);
         last_pass = (pass_q == 3'd1);
      end
   end

   // Neighbour selection folds the symmetric extension x[-1]=x[1], x[N]=x[N-2] into the addresses.
   always_comb begin
      half    = len_q >> 1;
      two_pos = pos_q << 1;
      if (desc.odd) begin
         idx_t = AW'(two_pos + ONE);
         idx_l = AW'(two_pos);
         idx_r = (two_pos + TWO < len_q) ? AW'(two_pos + TWO) : AW'(len_q - TWO);
      end else begin
         idx_t = AW'(two_pos);
         idx_l = (pos_q == '0) ? AW'(ONE) : AW'(two_pos - ONE);
         idx_r = AW'(two_pos + ONE);
      end
      nxt_lo = AW'(two_pos + TWO);
      nxt_hi = AW'(two_pos + TWO + ONE);
   end

   lift_step #(
      .IW   (IW),
      .FRAC (FRAC)
   ) u_lift_step (
      .mode53 (mode_q == MODE_53),
      .desc   (desc),
      .coef_b (CW'(C_IZETA)),
      .x_a    (x_q[idx_t]),
      .x_b    (x_q[idx_r]),
      .l      (x_q[idx_l]),
      .r      (x_q[idx_r]),
      .y_a    (y_a),
      .y_b    (y_b)
   );

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      cnt_d       = cnt_q;
      len_d       = len_q;
      pass_d      = pass_q;
      pos_d       = pos_q;
      x_d         = x_q;
      err_d       = 1'b0;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_low_d   = out_low_q;
      out_high_d  = out_high_q;
      case (state_q)
         IDLE: if (accept) begin
            x_d[0] = IW'(in_data);
            mode_d = mode;
            cnt_d  = ONE;
            if (in_last) err_d = 1'b1;
            else         state_d = LOAD;
         end
         LOAD: if (accept) begin
            x_d[cnt_q[AW-1:0]] = IW'(in_data);
            if (in_last || cnt_q == LEN_MAX_M1) begin
               len_d  = cnt_q + ONE;
               pass_d = '0;
               pos_d  = '0;
               if (!cnt_q[0]) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = COMPUTE;
               end
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         COMPUTE: begin
            x_d[idx_t] = y_a;
            if (desc.is_scale) x_d[idx_r] = y_b;
            if (pos_q == half - ONE) begin
               pos_d = '0;
               if (last_pass) begin
                  // First pair is taken from the post-write buffer so N=2 sees its own final update.
                  state_d     = DRAIN;
                  out_valid_d = 1'b1;
                  out_last_d  = (half == ONE);
                  out_low_d   = sat_out(x_d[0]);
                  out_high_d  = sat_out(x_d[1]);
               end else begin
                  pass_d = pass_q + 3'd1;
               end
            end else begin
               pos_d = pos_q + ONE;
            end
         end
         DRAIN: if (out_ready) begin
            if (out_last_q) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
            end else begin
               pos_d      = pos_q + ONE;
               out_last_d = (pos_q + TWO == half);
               out_low_d  = sat_out(x_q[nxt_lo]);
               out_high_d = sat_out(x_q[nxt_hi]);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         mode_q      <= MODE_97;
         cnt_q       <= '0;
         len_q       <= '0;
         pass_q      <= '0;
         pos_q       <= '0;
         x_q         <= '{default: '0};
         err_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_low_q   <= '0;
         out_high_q  <= '0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         pass_q      <= pass_d;
         pos_q       <= pos_d;
         x_q         <= x_d;
         err_q       <= err_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_low_q   <= out_low_d;
         out_high_q  <= out_high_d;
      end
   end

endmodule

// File: tb/tb_dwt_line_lift.sv
// Randomised self-checking bench for dwt_line_lift against an array-based lifting model.
module tb_dwt_line_lift;

   localparam int W  = 16;
   localparam int ML = 64;
   localparam int FR = 12;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic mode = 1'b0;
   logic in_valid = 1'b0;
   logic in_last = 1'b0;
   logic out_ready = 1'b0;
   logic signed [W-1:0] in_data = '0;
   logic in_ready, out_valid, out_last, busy, err;
   logic signed [W-1:0] out_low, out_high;

   int total = 0;
   int bad = 0;
   int stim [ML];
   longint mx [ML];
   longint exp_l [ML/2];
   longint exp_h [ML/2];
   longint got_h [ML/2];

   dwt_line_lift #(
      .WIDTH   (W),
      .MAX_LEN (ML),
      .FRAC    (FR)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .mode      (mode),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_low   (out_low),
      .out_high  (out_high),
      .out_last  (out_last),
      .busy      (busy),
      .err       (err)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic longint xe(input int i, input int n);
      int j = i;
      if (j < 0) j = -j;
      if (j >= n) j = 2 * n - 2 - j;
      return mx[j];
   endfunction

   function automatic longint rnd(input longint v);
      return (v + (64'sd1 <<< (FR - 1))) >>> FR;
   endfunction

   function automatic longint sat_w(input longint v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic void lift97(input int n, input int par, input longint c);
      for (int i = par; i < n; i += 2) mx[i] = mx[i] + rnd(c * (xe(i - 1, n) + xe(i + 1, n)));
   endfunction

   function automatic void ref_model(input int n, input bit m53);
      for (int i = 0; i < n; i++) mx[i] = stim[i];
      if (m53) begin
         for (int i = 1; i < n; i += 2) mx[i] = mx[i] - ((mx[i - 1] + xe(i + 1, n)) >>> 1);
         for (int i = 0; i < n; i += 2) mx[i] = mx[i] + ((xe(i - 1, n) + mx[i + 1] + 2) >>> 2);
         for (int k = 0; k < n / 2; k++) begin
            exp_l[k] = sat_w(mx[2 * k]);
            exp_h[k] = sat_w(mx[2 * k + 1]);
         end
      end else begin
         lift97(n, 1, -6497);
         lift97(n, 0, -217);
         lift97(n, 1, 3616);
         lift97(n, 0, 1817);
         for (int k = 0; k < n / 2; k++) begin
            exp_l[k] = sat_w(rnd(4709 * mx[2 * k]));
            exp_h[k] = sat_w(rnd(3563 * mx[2 * k + 1]));
         end
      end
   endfunction

   // ---------------- drivers ----------------
   task automatic send_line(input int n, input bit m53, input bit use_last);
      for (int i = 0; i < n; i++) begin
         int t = 0;
         @(negedge clk);
         if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(negedge clk);
         end
         in_valid = 1'b1;
         in_data  = W'(stim[i]);
         in_last  = use_last && (i == n - 1);
         mode     = (i == 0) ? m53 : 1'($urandom_range(0, 1));
         while (!in_ready && t < 500) begin
            @(negedge clk);
            t++;
         end
         total++;
         if (in_ready !== 1'b1) begin
            $display("FAIL send_ready sample=%0d actual=%b required=1", i, in_ready);
            bad++;
         end
         @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic run_line(input int n, input bit m53, input bit use_last, input bit rand_ready,
                           input int exp_cyc);
      int cyc = 0;
      int k = 0;
      int t = 0;
      bit hold = 1'b0;
      logic signed [W-1:0] hl, hh, el, eh;
      send_line(n, m53, use_last);
      while (!out_valid && cyc < 2000) begin
         cyc++;
         @(negedge clk);
      end
      total++;
      if (cyc != exp_cyc) begin
         $display("FAIL compute_cycles n=%0d actual=%0d required=%0d", n, cyc, exp_cyc);
         bad++;
      end
      while (k < n / 2 && t < 4000) begin
         if (out_valid) begin
            total++;
            if (in_ready !== 1'b0) begin
               $display("FAIL drain_in_ready k=%0d actual=%b required=0", k, in_ready);
               bad++;
            end
            if (hold) begin
               total++;
               if (out_low !== hl || out_high !== hh) begin
                  $display("FAIL hold_stable k=%0d actual=%0d/%0d required=%0d/%0d",
                           k, out_low, out_high, hl, hh);
                  bad++;
               end
            end
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_ready) begin
               el = W'(exp_l[k]);
               eh = W'(exp_h[k]);
               got_h[k] = out_high;
               total += 3;
               if (out_low !== el) begin
                  $display("FAIL low k=%0d actual=%0d required=%0d", k, out_low, el);
                  bad++;
               end
               if (out_high !== eh) begin
                  $display("FAIL high k=%0d actual=%0d required=%0d", k, out_high, eh);
                  bad++;
               end
               if (out_last !== (k == n / 2 - 1)) begin
                  $display("FAIL out_last k=%0d actual=%b required=%b", k, out_last, k == n / 2 - 1);
                  bad++;
               end
               k++;
               hold = 1'b0;
            end else begin
               hold = 1'b1;
               hl = out_low;
               hh = out_high;
            end
         end else begin
            out_ready = 1'b0;
         end
         @(negedge clk);
         t++;
      end
      total++;
      if (k != n / 2) begin
         $display("FAIL pair_count n=%0d actual=%0d required=%0d", n, k, n / 2);
         bad++;
      end
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         $display("FAIL post_drain actual=valid%b/busy%b required=valid0/busy0", out_valid, busy);
         bad++;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      repeat (2) @(negedge clk);
      total++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || err !== 1'b0 ||
          out_last !== 1'b0 || out_low !== 16'sd0 || out_high !== 16'sd0) begin
         $display("FAIL reset_state actual=rdy%b busy%b v%b e%b l%b %0d/%0d required=rdy1 busy0 v0 e0 l0 0/0",
                  in_ready, busy, out_valid, err, out_last, out_low, out_high);
         bad++;
      end
      resetn = 1'b1;
   endtask

   task automatic test_ramp53();
      for (int i = 0; i < 8; i++) stim[i] = i;
      for (int k = 0; k < 4; k++) begin
         exp_l[k] = 2 * k;
         exp_h[k] = (k == 3) ? 1 : 0;
      end
      run_line(8, 1'b1, 1'b1, 1'b0, 8);
   endtask

   task automatic test_const();
      for (int i = 0; i < 8; i++) stim[i] = 10;
      for (int k = 0; k < 4; k++) begin
         exp_l[k] = 10;
         exp_h[k] = 0;
      end
      run_line(8, 1'b1, 1'b1, 1'b1, 8);
      for (int i = 0; i < 8; i++) stim[i] = 100;
      ref_model(8, 1'b0);
      run_line(8, 1'b0, 1'b1, 1'b0, 20);
      for (int k = 0; k < 4; k++) begin
         total++;
         if (got_h[k] < -1 || got_h[k] > 1) begin
            $display("FAIL const97_high_range k=%0d actual=%0d required=-1..1", k, got_h[k]);
            bad++;
         end
      end
   endtask

   task automatic test_random97();
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 16; i++) stim[i] = int'($urandom_range(0, 32768)) - 16384;
         ref_model(16, 1'b0);
         run_line(16, 1'b0, 1'b1, 1'b1, 40);
      end
   endtask

   task automatic test_lengths();
      int n;
      for (int i = 0; i < 2; i++) stim[i] = int'($urandom_range(0, 65535)) - 32768;
      ref_model(2, 1'b1);
      run_line(2, 1'b1, 1'b1, 1'b1, 2);
      for (int i = 0; i < 2; i++) stim[i] = int'($urandom_range(0, 32768)) - 16384;
      ref_model(2, 1'b0);
      run_line(2, 1'b0, 1'b1, 1'b0, 5);
      for (int i = 0; i < ML; i++) stim[i] = int'($urandom_range(0, 65535)) - 32768;
      ref_model(ML, 1'b1);
      run_line(ML, 1'b1, 1'b0, 1'b1, ML);
      for (int i = 0; i < ML; i++) stim[i] = int'($urandom_range(0, 32768)) - 16384;
      ref_model(ML, 1'b0);
      run_line(ML, 1'b0, 1'b1, 1'b1, 5 * ML / 2);
      for (int r = 0; r < 3; r++) begin
         n = 2 * int'($urandom_range(2, 31));
         for (int i = 0; i < n; i++) stim[i] = int'($urandom_range(0, 65535)) - 32768;
         ref_model(n, 1'b1);
         run_line(n, 1'b1, 1'b1, 1'b1, n);
      end
   endtask

   task automatic test_odd();
      int errs = 0;
      int vlds = 0;
      for (int i = 0; i < 5; i++) stim[i] = int'($urandom_range(0, 200)) - 100;
      send_line(5, 1'b1, 1'b1);
      for (int c = 0; c < 12; c++) begin
         if (err) errs++;
         if (out_valid) vlds++;
         @(negedge clk);
      end
      total += 3;
      if (errs != 1) begin
         $display("FAIL odd_err_pulse actual=%0d required=1", errs);
         bad++;
      end
      if (vlds != 0) begin
         $display("FAIL odd_no_output actual=%0d required=0", vlds);
         bad++;
      end
      if (busy !== 1'b0 || in_ready !== 1'b1) begin
         $display("FAIL odd_idle actual=busy%b/rdy%b required=busy0/rdy1", busy, in_ready);
         bad++;
      end
      for (int i = 0; i < 6; i++) stim[i] = int'($urandom_range(0, 65535)) - 32768;
      ref_model(6, 1'b1);
      run_line(6, 1'b1, 1'b1, 1'b0, 6);
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 16; i++) stim[i] = int'($urandom_range(0, 32768)) - 16384;
      send_line(16, 1'b0, 1'b1);
      repeat (10) @(negedge clk);
      total++;
      if (busy !== 1'b1) begin
         $display("FAIL mid_busy actual=%b required=1", busy);
         bad++;
      end
      resetn = 1'b0;
      #1;
      total++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
          out_low !== 16'sd0 || out_high !== 16'sd0) begin
         $display("FAIL mid_compute_reset actual=busy%b v%b rdy%b %0d/%0d required=busy0 v0 rdy1 0/0",
                  busy, out_valid, in_ready, out_low, out_high);
         bad++;
      end
      @(negedge clk);
      resetn = 1'b1;
      for (int i = 0; i < 4; i++) stim[i] = 1000 + 300 * i;
      send_line(4, 1'b1, 1'b1);
      repeat (8) @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_low === 16'sd0) begin
         $display("FAIL drain_setup actual=v%b low%0d required=v1 low!=0", out_valid, out_low);
         bad++;
      end
      resetn = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || out_low !== 16'sd0 || out_high !== 16'sd0 || out_last !== 1'b0) begin
         $display("FAIL mid_drain_reset actual=v%b %0d/%0d l%b required=v0 0/0 l0",
                  out_valid, out_low, out_high, out_last);
         bad++;
      end
      @(negedge clk);
      resetn = 1'b1;
      for (int i = 0; i < 4; i++) stim[i] = int'($urandom_range(0, 32768)) - 16384;
      ref_model(4, 1'b0);
      run_line(4, 1'b0, 1'b1, 1'b1, 10);
   endtask

   initial begin
      test_reset();
      test_ramp53();
      test_const();
      test_random97();
      test_lengths();
      test_odd();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
